// File: rtl/wb_decoder.sv
// wb_decoder: single-master to four-slave Wishbone decoder with sticky slave select and hung-cycle timeout
module wb_decoder #(
  parameter logic [31:0] BASE0 = 32'h0000_0000,
  parameter logic [31:0] BASE1 = 32'h1000_0000,
  parameter logic [31:0] BASE2 = 32'h2000_0000,
  parameter logic [31:0] BASE3 = 32'h3000_0000,
  parameter logic [31:0] MASK0 = 32'hF000_0000,
  parameter logic [31:0] MASK1 = 32'hF000_0000,
  parameter logic [31:0] MASK2 = 32'hF000_0000,
  parameter logic [31:0] MASK3 = 32'hF000_0000,
  parameter int TO_W = 8,
  parameter logic [TO_W-1:0] TIMEOUT = 8'd255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic [31:0]  wbm_adr_i,
  input  logic [31:0]  wbm_dat_i,
  input  logic [3:0]   wbm_sel_i,
  input  logic [2:0]   wbm_cti_i,
  input  logic [1:0]   wbm_bte_i,
  input  logic         wbm_cyc_i,
  input  logic         wbm_stb_i,
  input  logic         wbm_we_i,
  output logic [31:0]  wbm_dat_o,
  output logic         wbm_ack_o,
  output logic         wbm_err_o,
  output logic [31:0]  wbs_adr_o,
  output logic [31:0]  wbs_dat_o,
  output logic [3:0]   wbs_sel_o,
  output logic [2:0]   wbs_cti_o,
  output logic [1:0]   wbs_bte_o,
  output logic         wbs_we_o,
  output logic [3:0]   wbs_cyc_o,
  output logic [3:0]   wbs_stb_o,
  input  logic [127:0] wbs_dat_i,
  input  logic [3:0]   wbs_ack_i,
  output logic [1:0]   wbslave_o
);
  typedef enum logic [1:0] {IDLE, ACTIVE, ERR, DRAIN} state_t;
  state_t state, state_nxt;
  logic [1:0] sel, sel_nxt, hit_idx;
  logic [TO_W-1:0] timer, timer_nxt;
  logic [3:0] hit;
  logic ack_sel;
  assign hit = {(wbm_adr_i & MASK3) == BASE3, (wbm_adr_i & MASK2) == BASE2,
                (wbm_adr_i & MASK1) == BASE1, (wbm_adr_i & MASK0) == BASE0};
  assign hit_idx = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
  assign ack_sel = wbs_ack_i[sel];
  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_sel_o = wbm_sel_i;
  assign wbs_cti_o = wbm_cti_i;
  assign wbs_bte_o = wbm_bte_i;
  assign wbs_we_o = wbm_we_i;
  assign wbslave_o = sel;
  always_comb begin
    state_nxt = state;
    sel_nxt = sel;
    timer_nxt = '0;
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_dat_o = '0;
    case (state)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          state_nxt = |hit ? ACTIVE : ERR;
          sel_nxt = |hit ? hit_idx : sel;
        end
      end
      ACTIVE: begin
        wbs_cyc_o[sel] = wbm_cyc_i;
        wbs_stb_o[sel] = wbm_stb_i;
        wbm_ack_o = ack_sel;
        wbm_dat_o = wbs_dat_i[{sel, 5'd0} +: 32];
        timer_nxt = (wbm_stb_i && !ack_sel) ? ((timer == '1) ? timer : timer + TO_W'(1)) : '0;
        state_nxt = !wbm_cyc_i ? IDLE : (wbm_stb_i && !ack_sel && timer == TIMEOUT) ? ERR : ACTIVE;
      end
      ERR: begin
        wbm_err_o = 1'b1;
        wbm_dat_o = 32'hDEAD_BEEF;
        state_nxt = DRAIN;
      end
      default: state_nxt = wbm_cyc_i ? DRAIN : IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      sel <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      sel <= sel_nxt;
      timer <= timer_nxt;
    end
  end
endmodule

// File: tb/tb_wb_decoder.sv
// tb_wb_decoder: vector table, random transactions against a window model, and hand sequences
// for burst stickiness, unmapped error, hung-slave timeout, ack-at-timeout and async reset.
module tb_wb_decoder;
  logic         wb_clk_i = 1'b0;
  logic         wb_rst_ni = 1'b0;
  logic [31:0]  wbm_adr_i = '0, wbm_dat_i = '0;
  logic [3:0]   wbm_sel_i = 4'hF;
  logic [2:0]   wbm_cti_i = '0;
  logic [1:0]   wbm_bte_i = '0;
  logic         wbm_cyc_i = 1'b0, wbm_stb_i = 1'b0, wbm_we_i = 1'b0;
  logic [31:0]  wbm_dat_o;
  logic         wbm_ack_o, wbm_err_o;
  logic [31:0]  wbs_adr_o, wbs_dat_o;
  logic [3:0]   wbs_sel_o;
  logic [2:0]   wbs_cti_o;
  logic [1:0]   wbs_bte_o;
  logic         wbs_we_o;
  logic [3:0]   wbs_cyc_o, wbs_stb_o;
  logic [127:0] wbs_dat_i = '0;
  logic [3:0]   wbs_ack_i = '0;
  logic [1:0]   wbslave_o;
  int total = 0, bad = 0;

  wb_decoder dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i), .wbm_cyc_i(wbm_cyc_i),
    .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o), .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
    .wbslave_o(wbslave_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] adr;
    int          lat;
    logic [31:0] d;
    int          s;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each slave owns one 256 MiB window starting at index*0x1000_0000; anything above is unmapped.
  function automatic int ref_slave(input logic [31:0] a);
    int w;
    w = int'(a / 32'h1000_0000);
    return (w < 4) ? w : 4;
  endfunction

  task automatic drop_cyc(input string tag);
    @(posedge wb_clk_i); #1;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbs_ack_i = '0; wbm_cti_i = '0;
    @(negedge wb_clk_i);
    chk({tag, " drop cyc"}, wbs_cyc_o, 0);
    chk({tag, " drop ack/err"}, {wbm_ack_o, wbm_err_o}, 0);
  endtask

  task automatic txn(input logic [31:0] adr, input int lat, input logic [31:0] d, input int s, input string tag);
    logic [3:0] oh;
    oh = (s < 4) ? 4'(1 << s) : 4'b0;
    @(posedge wb_clk_i); #1;
    wbm_adr_i = adr; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_we_i = 1'($urandom);
    wbm_dat_i = $urandom;
    wbs_dat_i = {$urandom, $urandom, $urandom, $urandom};
    if (s < 4) wbs_dat_i[32*s +: 32] = d;
    wbs_ack_i = 4'($urandom);
    @(negedge wb_clk_i);
    chk({tag, " decode cyc"}, wbs_cyc_o, 0);
    chk({tag, " decode ack/err"}, {wbm_ack_o, wbm_err_o}, 0);
    chk({tag, " adr passthru"}, wbs_adr_o, adr);
    if (s < 4) begin
      for (int i = 0; i <= lat; i++) begin
        @(posedge wb_clk_i); #1;
        wbs_ack_i = (4'($urandom) & ~oh) | ((i == lat) ? oh : 4'b0);
        @(negedge wb_clk_i);
        chk({tag, " cyc"}, wbs_cyc_o, oh);
        chk({tag, " stb"}, wbs_stb_o, oh);
        chk({tag, " ack"}, wbm_ack_o, (i == lat));
        chk({tag, " err"}, wbm_err_o, 0);
        chk({tag, " slave idx"}, wbslave_o, s);
        if (i == lat) chk({tag, " rdata"}, wbm_dat_o, d);
      end
    end else begin
      @(posedge wb_clk_i); #1;
      @(negedge wb_clk_i);
      chk({tag, " unmapped err"}, wbm_err_o, 1);
      chk({tag, " unmapped ack"}, wbm_ack_o, 0);
      chk({tag, " unmapped dat"}, wbm_dat_o, 32'hDEAD_BEEF);
      chk({tag, " unmapped cyc"}, wbs_cyc_o, 0);
      @(posedge wb_clk_i); #1;
      @(negedge wb_clk_i);
      chk({tag, " drain err"}, wbm_err_o, 0);
      chk({tag, " drain cyc"}, wbs_cyc_o, 0);
    end
    drop_cyc(tag);
  endtask

  // Stall the given slave; ack_at<0 means it never answers.
  task automatic hang(input logic [31:0] adr, input int s, input int ack_at, input string tag);
    logic [3:0] oh;
    int cnt;
    bit got_err, got_ack;
    logic [3:0] cyc_at_end;
    oh = 4'(1 << s);
    cnt = 0; got_err = 0; got_ack = 0; cyc_at_end = 'x;
    @(posedge wb_clk_i); #1;
    wbm_adr_i = adr; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbs_ack_i = '0;
    wbs_dat_i[32*s +: 32] = 32'h5A5A_0000 + 32'(s);
    @(negedge wb_clk_i);
    for (int i = 0; i < 300 && !got_err && !got_ack; i++) begin
      @(posedge wb_clk_i); #1;
      wbs_ack_i = (i == ack_at) ? oh : 4'b0;
      @(negedge wb_clk_i);
      if (wbm_err_o) begin got_err = 1; cyc_at_end = wbs_cyc_o; end
      else if (wbm_ack_o) got_ack = 1;
      else if (wbs_cyc_o == oh) cnt++;
    end
    if (ack_at < 0) begin
      chk({tag, " err seen"}, got_err, 1);
      chk({tag, " stalled cycles before err"}, cnt, 256);
      chk({tag, " cyc at err"}, cyc_at_end, 0);
      @(posedge wb_clk_i); #1;
      @(negedge wb_clk_i);
      chk({tag, " err one cycle"}, wbm_err_o, 0);
      chk({tag, " cyc after err"}, wbs_cyc_o, 0);
    end else begin
      chk({tag, " ack seen"}, got_ack, 1);
      chk({tag, " no err"}, got_err, 0);
      chk({tag, " cycles before ack"}, cnt, ack_at);
      chk({tag, " ack dat"}, wbm_dat_o, 32'h5A5A_0000 + 32'(s));
      for (int i = 0; i < 2; i++) begin
        @(posedge wb_clk_i); #1;
        wbs_ack_i = '0;
        @(negedge wb_clk_i);
        chk({tag, " post-ack err"}, wbm_err_o, 0);
        chk({tag, " post-ack cyc"}, wbs_cyc_o, oh);
      end
    end
    drop_cyc(tag);
  endtask

  vec_t v[8];

  initial begin
    v[0] = '{32'h2000_0010, 3, 32'h1234_5678, 2};
    v[1] = '{32'h0000_0000, 0, 32'hA5A5_0001, 0};
    v[2] = '{32'h1FFF_FFFC, 1, 32'h0BAD_F00D, 1};
    v[3] = '{32'h3000_0000, 2, 32'hCAFE_0003, 3};
    v[4] = '{32'h4000_0000, 0, 32'h0000_0000, 4};
    v[5] = '{32'hFFFF_FFFF, 0, 32'h0000_0000, 4};
    v[6] = '{32'h0FFF_FFFF, 5, 32'h7777_0000, 0};
    v[7] = '{32'h3FFF_FFFF, 0, 32'h1111_2222, 3};

    #2;
    chk("reset cyc", wbs_cyc_o, 0);
    chk("reset ack/err", {wbm_ack_o, wbm_err_o}, 0);
    chk("reset dat", wbm_dat_o, 0);
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;

    foreach (v[k]) txn(v[k].adr, v[k].lat, v[k].d, v[k].s, $sformatf("vec%0d", k));

    // cyc without stb must not start a decode
    @(posedge wb_clk_i); #1;
    wbm_adr_i = 32'h1000_0000; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b0; wbs_ack_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      chk("cyc-only cyc", wbs_cyc_o, 0);
      chk("cyc-only ack", wbm_ack_o, 0);
      @(posedge wb_clk_i); #1;
    end
    txn(32'h1000_0040, 1, 32'hC0C0_1111, 1, "after cyc-only");

    // burst starting in slave0 and walking into slave1's window stays on slave0
    @(posedge wb_clk_i); #1;
    wbm_adr_i = 32'h0FFF_FFF8; wbm_cti_i = 3'b010; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbs_ack_i = '0;
    @(negedge wb_clk_i);
    chk("burst decode cyc", wbs_cyc_o, 0);
    for (int b = 0; b < 4; b++) begin
      @(posedge wb_clk_i); #1;
      wbm_adr_i = 32'h0FFF_FFF8 + 32'(4 * b);
      wbm_cti_i = (b == 3) ? 3'b111 : 3'b010;
      wbs_ack_i = 4'b0011;
      wbs_dat_i[31:0] = 32'hB000_0000 + 32'(b);
      wbs_dat_i[63:32] = 32'hFFFF_FFFF;
      @(negedge wb_clk_i);
      chk("burst cyc", wbs_cyc_o, 4'b0001);
      chk("burst ack", wbm_ack_o, 1);
      chk("burst dat", wbm_dat_o, 32'hB000_0000 + 32'(b));
    end
    drop_cyc("burst");

    hang(32'h3000_0000, 3, -1, "timeout s3");
    hang(32'h1000_0000, 1, 255, "ack at timeout s1");

    // async reset in the middle of a slave1 burst
    @(posedge wb_clk_i); #1;
    wbm_adr_i = 32'h1000_0000; wbm_cti_i = 3'b010; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbs_ack_i = '0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    wbs_ack_i = 4'b0010; wbs_dat_i[63:32] = 32'h0101_0101;
    #1;
    chk("pre-reset cyc", wbs_cyc_o, 4'b0010);
    chk("pre-reset ack", wbm_ack_o, 1);
    wb_rst_ni = 1'b0;
    #1;
    chk("async reset cyc", wbs_cyc_o, 0);
    chk("async reset stb", wbs_stb_o, 0);
    chk("async reset ack/err", {wbm_ack_o, wbm_err_o}, 0);
    chk("async reset dat", wbm_dat_o, 0);
    chk("async reset idx", wbslave_o, 0);
    @(posedge wb_clk_i); #1;
    wb_rst_ni = 1'b1; wbs_ack_i = '0;
    @(negedge wb_clk_i);
    chk("post-reset idle cyc", wbs_cyc_o, 0);
    @(posedge wb_clk_i); #1;
    @(negedge wb_clk_i);
    chk("post-reset active cyc", wbs_cyc_o, 4'b0010);
    drop_cyc("post-reset");

    for (int r = 0; r < 40; r++) begin
      logic [31:0] a;
      a = {4'($urandom_range(0, 5)), 28'($urandom)};
      txn(a, $urandom_range(0, 6), $urandom, ref_slave(a), $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
